strait_result_reader: RTL and testbench
=======================================

Name: strait_result_reader

Overview:
- Downstream consumer of the STRAIT top in normal (non-test) mode.
- On a start pulse it sweeps the accumulator read address `rd_addr` over rows 0..SYSTOLIC_SIZE-1 and captures `partial_sum_outputs_flat_outside` after a fixed read latency.
- Captured rows are buffered in a small credit-controlled FIFO and streamed out on a valid/ready interface, tagged with row index and last flag.
- Decouples the host's backpressure from the accumulator's fixed-latency read port.

Parameters:
- SYSTOLIC_SIZE, 8, rows/lanes per result block.
- PARTIAL_SUM_WIDTH, 19, bits per lane; signed two's complement.
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row address width.
- RD_LATENCY, 1, cycles from `acc_rd_addr` change to valid `acc_rd_data`; legal range 0..3.
- FIFO_DEPTH, 4, output buffer entries; must be ≥ RD_LATENCY+1 and a power of two.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request to read one full block.
- test_mode, input, 1, STRAIT test mode; high aborts or blocks reads.
- acc_rd_addr, output, ADDR_WIDTH, drives STRAIT `rd_addr`.
- acc_rd_data, input, SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH, from STRAIT `partial_sum_outputs_flat_outside`.
- out_valid, output, 1, output row available.
- out_ready, input, 1, consumer accepts row.
- out_data, output, SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH, row data; lane i at bits [i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH].
- out_row, output, ADDR_WIDTH, row index of out_data.
- out_last, output, 1, high with row SYSTOLIC_SIZE-1.
- busy, output, 1, high from accepted start until done or abort.
- done, output, 1, one-cycle pulse when the last row is accepted.

Behaviour:
- Reset: acc_rd_addr=0, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, done=0. FIFO empty, in-flight pipe cleared, FSM=IDLE. Reset is honoured at any time, including mid-sweep; no partial output survives it.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: start=1 and test_mode=0 → ISSUE; busy=1 the next cycle; issue counter=0. start while test_mode=1 is ignored.
- ISSUE: one read is issued per cycle when credit is available, i.e. fifo_count + inflight < FIFO_DEPTH.
  - Issue = drive acc_rd_addr=issue_cnt and push tag {row} into a RD_LATENCY-deep shift pipe.
  - The tag emerges RD_LATENCY cycles later and acc_rd_data is written into the FIFO that cycle.
  - RD_LATENCY=0 writes in the issue cycle.
  - After issuing row SYSTOLIC_SIZE-1 → DRAIN.
  - No credit: hold acc_rd_addr; no issue.
- DRAIN: wait until inflight=0, FIFO empty and the last row is accepted. Then done=1 for one cycle, busy=0, → IDLE.
- Output handshake:
  - Transfer when out_valid & out_ready.
  - out_valid reflects FIFO non-empty. out_data/out_row/out_last are the FIFO head and stay stable while out_valid=1 & out_ready=0.
  - No combinational path from out_ready to out_valid.
- FIFO:
  - Simultaneous push and pop when full is impossible by credit rule.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Rows are emitted strictly in order 0..SYSTOLIC_SIZE-1; exactly SYSTOLIC_SIZE transfers per start.
- start while busy=1 is ignored; no queueing.
- test_mode rising while busy=1 (abort):
  - Next cycle: FIFO and pipe flushed, out_valid=0, busy=0, FSM=IDLE, done NOT pulsed.
  - acc_rd_addr returns to 0.
- Throughput: with out_ready held high, one row per cycle. Total start-to-done = SYSTOLIC_SIZE + RD_LATENCY + 1 cycles.

Optional Feature:
- Macro STRAIT_RESULT_RELU_EN.
- Defined: each lane is clamped to 0 if its MSB is 1, applied at the FIFO write. Stored and emitted values are ReLU outputs.
- Undefined: lanes pass through bit-exact. No extra logic; the same latency in both builds.

Test Plan:
- Basic sweep, RD_LATENCY=1, out_ready=1, lane i of row r returns r*16+i; pulse start → rows 0..7 on 8 consecutive cycles, out_last only on row 7, done 10 cycles after start, busy low the cycle after done.
- Backpressure: out_ready=0 for 20 cycles after start, FIFO_DEPTH=4 → exactly 4 rows issued and buffered, acc_rd_addr holds at 4, out_data stable. Release → rows 0..7 in order, no duplicate or drop.
- Random out_ready (50%), RD_LATENCY=3 → 8 in-order transfers matching the model, one done pulse, FIFO never overflows (assertion).
- Abort: test_mode=1 after row 2 accepted → next cycle out_valid=0, busy=0, no done; subsequent start with test_mode=0 restarts at row 0.
- start during busy, and start with test_mode=1 → ignored; rst_n low mid-sweep → all outputs at reset values immediately (asynchronous).
- STRAIT_RESULT_RELU_EN defined: lane value 19'h7FFFF (−1) → 0, 19'h00005 → 5; undefined build: both pass unchanged.

Source files
------------

// File: rtl/strait_result_reader.sv
// strait_result_reader: after a start pulse, sweeps the STRAIT accumulator rows and streams them out
// through a credit-controlled FIFO. Build option STRAIT_RESULT_RELU_EN clamps negative lanes to zero at the FIFO write.
`timescale 1ns/1ps
module strait_result_reader #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int PARTIAL_SUM_WIDTH = 19,
  parameter int ADDR_WIDTH        = $clog2(SYSTOLIC_SIZE),
  parameter int RD_LATENCY        = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       test_mode,
  output logic [ADDR_WIDTH-1:0]                      acc_rd_addr,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] acc_rd_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]                      out_row,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       done
);
  localparam int ROW_W = SYSTOLIC_SIZE * PARTIAL_SUM_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] issue_cnt;
  logic                  busy_q;
  logic                  abort;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  done_w;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      inflight;
  logic [ADDR_WIDTH-1:0] wr_row;
  logic [ROW_W-1:0]      wr_data;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [ROW_W-1:0]      mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_row  [FIFO_DEPTH];

`ifdef STRAIT_RESULT_RELU_EN
  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
    logic signed [PARTIAL_SUM_WIDTH-1:0] lane;
    relu_row = row;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      lane = row[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH];
      if (lane < 0) relu_row[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] = '0;
    end
  endfunction

  assign wr_data = relu_row(acc_rd_data);
`else
  assign wr_data = acc_rd_data;
`endif

  // Any test_mode assertion during a block flushes everything; start under test_mode never gets here.
  assign abort  = busy_q && test_mode;
  // Credit counts rows already buffered plus rows still inside the read latency.
  assign issue  = (state == ISSUE) && !test_mode && ((fifo_count + inflight) < DEPTH_C);
  assign pop    = out_valid && out_ready;
  assign done_w = (state == DRAIN) && !test_mode && pop && out_last &&
                  (inflight == '0) && (fifo_count == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      busy_q    <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      issue_cnt <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !test_mode) begin
            state     <= ISSUE;
            issue_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (issue_cnt == LAST_ROW) begin
              issue_cnt <= '0;
              state     <= DRAIN;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (done_w) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency tag pipe: a row tag travels alongside the accumulator read it belongs to.
  generate
    if (RD_LATENCY == 0) begin : g_direct
      assign push     = issue;
      assign wr_row   = issue_cnt;
      assign inflight = '0;
    end else begin : g_pipe
      logic                  vld_p [RD_LATENCY];
      logic [ADDR_WIDTH-1:0] row_p [RD_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= 1'b0;
        end else if (abort) begin
          for (int i = 0; i < RD_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
          vld_p[0] <= issue;
          for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        row_p[0] <= issue_cnt;
        for (int i = 1; i < RD_LATENCY; i++) row_p[i] <= row_p[i-1];
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(vld_p[i]);
      end

      assign push   = vld_p[RD_LATENCY-1];
      assign wr_row = row_p[RD_LATENCY-1];
    end
  endgenerate

  // Output FIFO: control state is reset/flushed, storage is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= wr_data;
      mem_row[wr_ptr]  <= wr_row;
    end
  end

  // Head outputs are masked while empty so nothing stale is visible after reset or abort.
  assign out_valid   = (fifo_count != '0);
  assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
  assign out_row     = out_valid ? mem_row[rd_ptr] : '0;
  assign out_last    = out_valid && (mem_row[rd_ptr] == LAST_ROW);
  assign acc_rd_addr = issue_cnt;
  assign busy        = busy_q;
  assign done        = done_w;

endmodule

// File: tb/tb_strait_result_reader.sv
// Scoreboard bench for strait_result_reader: two instances (read latency 1 and 3) share stimulus;
// each has its own accumulator model and expected-row queue checked by a monitor process.
`timescale 1ns/1ps
module tb_strait_result_reader;
  localparam int N  = 8;
  localparam int PW = 19;
  localparam int AW = 3;
  localparam int DW = N * PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          test_mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] addr1, addr3, row1, row3;
  logic [DW-1:0] rdata1, rdata3, odata1, odata3;
  logic [DW-1:0] a3_s0, a3_s1;
  logic          ov1, ov3, last1, last3, busy1, busy3, done1, done3;
  bit            neg_pat = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int done1_cnt = 0, done3_cnt = 0, done1_cyc = -1, ovf = 0;
  int acc1_cyc[$];

  typedef struct {
    int            row;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t q1[$];
  exp_t q3[$];

  strait_result_reader #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_mode(test_mode),
    .acc_rd_addr(addr1), .acc_rd_data(rdata1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(odata1), .out_row(row1),
    .out_last(last1), .busy(busy1), .done(done1)
  );

  strait_result_reader #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_mode(test_mode),
    .acc_rd_addr(addr3), .acc_rd_data(rdata3),
    .out_valid(ov3), .out_ready(out_ready), .out_data(odata3), .out_row(row3),
    .out_last(last3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator content: lane i of row r is r*16+i; the signed pattern puts -1 in lane 0 and 5 in lane 1.
  function automatic logic [DW-1:0] acc_row(input int r, input bit neg);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = PW'(r * 16 + i);
    if (neg) begin
      v[PW-1:0]    = 19'h7FFFF;
      v[2*PW-1:PW] = 19'h00005;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_row(input int r, input bit neg);
    logic [DW-1:0] v;
    v = acc_row(r, neg);
`ifdef STRAIT_RESULT_RELU_EN
    if (neg) v[PW-1:0] = '0;
`endif
    return v;
  endfunction

  always @(posedge clk) rdata1 <= acc_row(int'(addr1), neg_pat);
  always @(posedge clk) begin
    a3_s0  <= acc_row(int'(addr3), neg_pat);
    a3_s1  <= a3_s0;
    rdata3 <= a3_s1;
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake seen here completes at the next rising edge.
  initial begin
    exp_t e;
    logic done1_prev;
    done1_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ov1 && out_ready) begin
          acc1_cyc.push_back(cyc);
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_extra_row: got row %0d want no transfer", row1);
          end else begin
            e = q1.pop_front();
            chk_int("dut1_row", int'(row1), e.row);
            chk_data("dut1_data", odata1, e.data);
            chk_bit("dut1_last", last1, e.last);
          end
        end
        if (ov3 && out_ready) begin
          if (q3.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut3_extra_row: got row %0d want no transfer", row3);
          end else begin
            e = q3.pop_front();
            chk_int("dut3_row", int'(row3), e.row);
            chk_data("dut3_data", odata3, e.data);
            chk_bit("dut3_last", last3, e.last);
          end
        end
        if (done1_prev) chk_bit("dut1_busy_after_done", busy1, 1'b0);
        if (done1) begin done1_cnt++; done1_cyc = cyc; end
        if (done3) done3_cnt++;
        done1_prev = done1;
        if (dut1.fifo_count > 4 || dut3.fifo_count > 4) ovf++;
      end else begin
        done1_prev = 1'b0;
      end
    end
  end

  task automatic pulse_start(input bit push_exp, output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    if (push_exp) begin
      for (int r = 0; r < N; r++) begin
        q1.push_back('{row: r, data: exp_row(r, neg_pat), last: (r == N - 1)});
        q3.push_back('{row: r, data: exp_row(r, neg_pat), last: (r == N - 1)});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy1 || busy3 || q1.size() != 0 || q3.size() != 0) && n < 400);
    chk_bit({name, "_completes"}, (n < 400), 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int s, s2, d1, d3, n, first, lastc;
    bit found;

    // Reset values while rst_n is held low
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_valid1", ov1, 1'b0);
    chk_bit("rst_busy1", busy1, 1'b0);
    chk_bit("rst_done1", done1, 1'b0);
    chk_int("rst_addr1", int'(addr1), 0);
    chk_data("rst_data1", odata1, '0);
    chk_int("rst_row1", int'(row1), 0);
    chk_bit("rst_last1", last1, 1'b0);
    chk_bit("rst_valid3", ov3, 1'b0);
    chk_bit("rst_busy3", busy3, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic sweep, ready always high
    out_ready = 1'b1;
    acc1_cyc.delete();
    d1 = done1_cnt; d3 = done3_cnt;
    pulse_start(1'b1, s);
    wait_idle("basic");
    first = (acc1_cyc.size() > 0) ? acc1_cyc[0] - s : -1;
    lastc = (acc1_cyc.size() > 7) ? acc1_cyc[7] - s : -1;
    chk_int("basic_transfers", acc1_cyc.size(), 8);
    chk_int("basic_first_row_cycle", first, 3);
    chk_int("basic_last_row_cycle", lastc, 10);
    chk_int("basic_done_cycle", done1_cyc - s, 10);
    chk_int("basic_done1_count", done1_cnt - d1, 1);
    chk_int("basic_done3_count", done3_cnt - d3, 1);

    // Backpressure: ready low for 20 cycles, credit limits issue to FIFO_DEPTH rows
    out_ready = 1'b0;
    d1 = done1_cnt; d3 = done3_cnt;
    pulse_start(1'b1, s);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_data("bp_data1_mid", odata1, exp_row(0, 1'b0));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_int("bp_addr1", int'(addr1), 4);
    chk_int("bp_addr3", int'(addr3), 4);
    chk_bit("bp_valid1", ov1, 1'b1);
    chk_int("bp_row1", int'(row1), 0);
    chk_data("bp_data1_end", odata1, exp_row(0, 1'b0));
    chk_data("bp_data3_end", odata3, exp_row(0, 1'b0));
    chk_int("bp_no_done", done1_cnt - d1, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle("backpressure");
    chk_int("bp_done1_count", done1_cnt - d1, 1);
    chk_int("bp_done3_count", done3_cnt - d3, 1);

    // Random ready
    d1 = done1_cnt; d3 = done3_cnt;
    pulse_start(1'b1, s);
    n = 0;
    while ((busy1 || busy3 || q1.size() != 0 || q3.size() != 0) && n < 600) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk_bit("rand_completes", (n < 600), 1'b1);
    out_ready = 1'b1;
    chk_int("rand_done1_count", done1_cnt - d1, 1);
    chk_int("rand_done3_count", done3_cnt - d3, 1);

    // Abort after row 2 is accepted by the latency-1 instance
    d1 = done1_cnt; d3 = done3_cnt;
    pulse_start(1'b1, s);
    found = 1'b0;
    n = 0;
    while (!found && n < 50) begin
      @(negedge clk);
      n++;
      if (ov1 && out_ready && row1 == 3'd2) found = 1'b1;
    end
    chk_bit("abort_row2_seen", found, 1'b1);
    @(posedge clk); #1;
    test_mode = 1'b1;
    out_ready = 1'b0;
    q1.delete();
    q3.delete();
    @(posedge clk);
    @(negedge clk);
    chk_bit("abort_valid1", ov1, 1'b0);
    chk_bit("abort_busy1", busy1, 1'b0);
    chk_bit("abort_valid3", ov3, 1'b0);
    chk_bit("abort_busy3", busy3, 1'b0);
    chk_int("abort_addr1", int'(addr1), 0);
    chk_int("abort_addr3", int'(addr3), 0);
    repeat (3) @(posedge clk);
    #1;
    chk_int("abort_no_done1", done1_cnt - d1, 0);
    chk_int("abort_no_done3", done3_cnt - d3, 0);
    test_mode = 1'b0;
    out_ready = 1'b1;
    pulse_start(1'b1, s);
    wait_idle("restart");
    chk_int("restart_done1_count", done1_cnt - d1, 1);

    // start while test_mode is high is ignored
    test_mode = 1'b1;
    pulse_start(1'b0, s);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_bit("tm_start_busy1", busy1, 1'b0);
    chk_bit("tm_start_valid1", ov1, 1'b0);
    chk_bit("tm_start_busy3", busy3, 1'b0);
    @(posedge clk); #1 test_mode = 1'b0;

    // start while busy is ignored
    d1 = done1_cnt; d3 = done3_cnt;
    pulse_start(1'b1, s);
    repeat (2) @(posedge clk);
    pulse_start(1'b0, s2);
    wait_idle("busy_start");
    repeat (15) @(negedge clk);
    chk_int("busy_start_done1", done1_cnt - d1, 1);
    chk_int("busy_start_done3", done3_cnt - d3, 1);
    chk_bit("busy_start_idle1", busy1, 1'b0);

    // Asynchronous reset mid-sweep
    pulse_start(1'b1, s);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    q1.delete();
    q3.delete();
    #1;
    chk_bit("arst_valid1", ov1, 1'b0);
    chk_bit("arst_busy1", busy1, 1'b0);
    chk_int("arst_addr1", int'(addr1), 0);
    chk_data("arst_data1", odata1, '0);
    chk_int("arst_row1", int'(row1), 0);
    chk_bit("arst_last1", last1, 1'b0);
    chk_bit("arst_done1", done1, 1'b0);
    chk_bit("arst_valid3", ov3, 1'b0);
    chk_bit("arst_busy3", busy3, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Signed lanes: -1 and 5
    neg_pat = 1'b1;
    d1 = done1_cnt;
    pulse_start(1'b1, s);
    wait_idle("signed");
    chk_int("signed_done1_count", done1_cnt - d1, 1);
    neg_pat = 1'b0;

    chk_int("fifo_overflow", ovf, 0);
    chk_int("q1_drained", q1.size(), 0);
    chk_int("q3_drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
